logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
//  Shares one 32-bit bitwise logic unit (AND/OR) between NUM_REQ reservation-station entries.
//  Picks one ready requester per cycle, round-robin. Computes A|B or A&B.
//  Registers the result with its tag for broadcast on the common data bus (CDB).
//  Sits between the logic reservation stations and the CDB arbiter of the OoO core.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  TAG_W    4   ROB tag width
//  DATA_W   32  operand/result width
// PORTS
//  clock      in   1                clock; all state updates on rising edge
//  reset      in   1                synchronous, active-high reset
//  flush      in   1                branch-mispredict squash
//  req_valid  in   NUM_REQ          request i has operands ready
//  req_op     in   NUM_REQ          per-requester op: 0 = AND, 1 = OR
//  req_a      in   NUM_REQ*DATA_W   operand A; requester i in bits [i*DATA_W +: DATA_W]
//  req_b      in   NUM_REQ*DATA_W   operand B; same packing as req_a
//  req_tag    in   NUM_REQ*TAG_W    destination tag; requester i in bits [i*TAG_W +: TAG_W]
//  req_ready  out  NUM_REQ          one-hot grant; a transfer happens when valid & ready
//  cdb_valid  out  1                result register holds a valid result
//  cdb_ready  in   1                CDB accepts the result this cycle
//  cdb_tag    out  TAG_W            tag of the held result
//  cdb_data   out  DATA_W           held result
// BEHAVIOUR
//  - Reset values:
//      cdb_valid=0, cdb_tag=0, cdb_data=0, rr_ptr=0.
//      req_ready=0 while reset=1.
//  - accept = !flush & (!cdb_valid | cdb_ready).
//  - Grant search:
//      Combinational; starts at index rr_ptr and ascends with wrap.
//      The first i with req_valid[i] wins.
//      req_ready[i] = accept & win[i]. At most one bit is set.
//      req_ready may depend combinationally on req_valid. Requesters must not make
//      req_valid depend on req_ready.
//  - Transfer on requester i, i.e. accept & req_valid[i]:
//      Next cycle: cdb_valid=1, cdb_tag=req_tag[i].
//      cdb_data = req_op[i] ? (a|b) : (a&b).
//      rr_ptr <= (i+1) mod NUM_REQ.
//      Latency is exactly 1 cycle from handshake to cdb_valid.
//  - Throughput:
//      If cdb_ready is held high, one result per cycle.
//      Consume and refill in the same cycle is allowed; no bubble.
//  - Backpressure:
//      While cdb_valid & !cdb_ready, cdb_tag and cdb_data hold stable.
//      req_ready stays all-zero.
//  - Drain: if cdb_ready & no grant, then cdb_valid <= 0.
//      cdb_data and cdb_tag keep their old values.
//  - No request valid: rr_ptr holds, and no state changes except the drain above.
//  - Flush:
//      Next cycle cdb_valid=0, whatever cdb_ready is.
//      No grant in the flush cycle; rr_ptr holds.
//      Requests presented during flush are not consumed.
//  - Reset mid-operation: reset overrides flush and any handshake.
//      A held result is dropped, and the next cycle shows reset values.
//  - Arithmetic is purely bitwise with no carries. Widths are DATA_W in and DATA_W out.
// STRUCTURE
//  - Shared package logic_unit_pkg:
//      LOGIC_OP_AND = 1'b0, LOGIC_OP_OR = 1'b1.
//  - Sub-module rr_arbiter #(N):
//      Inputs: req[N], ptr, en.
//      Outputs: grant[N] (one-hot), grant_idx.
//      Pure combinational.
//  - The datapath reuses the existing 32-bit bitwise OR cell, plus a bitwise AND cell and a 2:1 mux.
//  - One result register with its valid flag, and one rr_ptr register. No further pipelining.
// TESTING
//  1. Reset, then req_valid=0001, op=OR, a=F0F0_0000, b=0000_0F0F, tag=3, cdb_ready=1:
//     -> req_ready=0001.
//     -> Next cycle cdb_valid=1, cdb_data=F0F0_0F0F, cdb_tag=3.
//  2. Round-robin: req_valid=1111 held for 5 cycles, cdb_ready=1
//     -> grants 0001, 0010, 0100, 1000, 0001 in that order.
//  3. Backpressure: result held with cdb_ready=0 for 3 cycles, req_valid=0110
//     -> req_ready=0000 and cdb_data/cdb_tag unchanged.
//     -> When cdb_ready=1, the grant goes to the next requester in the same cycle and cdb_valid stays 1.
//  4. AND op: a=FFFF_00FF, b=0F0F_0F0F, op=AND -> cdb_data=0F0F_000F.
//  5. Flush with cdb_valid=1, cdb_ready=0, req_valid=1000
//     -> req_ready=0000.
//     -> Next cycle cdb_valid=0, and rr_ptr is unchanged.
//  6. Reset asserted while cdb_valid=1 and a handshake is in progress
//     -> next cycle cdb_valid=0, cdb_tag=0, cdb_data=0.
//     -> The first grant afterwards with req_valid=1111 is 0001.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit and its requester arbiter.
package logic_unit_pkg;

  typedef enum logic {
    LOGIC_OP_AND = 1'b0,
    LOGIC_OP_OR  = 1'b1
  } logic_op_e;

  // Width of an index into n requesters, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
module rr_arbiter
  import logic_unit_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned PTR_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic             found;
  logic [PTR_W-1:0] sel;

  // Scan from ptr upward with wrap; en only gates the one-hot grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sel       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sel = PTR_W'((32'(ptr) + k) % N);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = en;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one AND/OR bitwise unit among NUM_REQ reservation-station entries and
// holds the selected result in a single register for the CDB.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_op,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        cdb_valid,
  input  logic                        cdb_ready,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data
);

  localparam int unsigned PTR_W = idx_width(NUM_REQ);

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q,   tag_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [PTR_W-1:0]  ptr_q,   ptr_d;

  logic              accept_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [PTR_W-1:0]  grant_idx_c;
  logic              xfer_c;

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic [TAG_W-1:0]  t_arr [NUM_REQ];

  logic [DATA_W-1:0] sel_a_c, sel_b_c, and_c, or_c, result_c;
  logic [TAG_W-1:0]  sel_tag_c;
  logic              sel_op_c;

  // A slot opens when the result register is empty or being consumed; reset also blocks grants.
  assign accept_c = !reset && !flush && (!valid_q || cdb_ready);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (accept_c),
    .grant     (grant_c),
    .grant_idx (grant_idx_c)
  );

  assign xfer_c    = |grant_c;
  assign req_ready = grant_c;

  // Unpack the flat requester buses into per-entry arrays.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*DATA_W +: DATA_W];
      b_arr[i] = req_b[i*DATA_W +: DATA_W];
      t_arr[i] = req_tag[i*TAG_W +: TAG_W];
    end
  end

  assign sel_a_c   = a_arr[grant_idx_c];
  assign sel_b_c   = b_arr[grant_idx_c];
  assign sel_tag_c = t_arr[grant_idx_c];
  assign sel_op_c  = req_op[grant_idx_c];

  // Shared datapath: OR cell, AND cell and a 2:1 select.
  assign or_c     = sel_a_c | sel_b_c;
  assign and_c    = sel_a_c & sel_b_c;
  assign result_c = (sel_op_c == LOGIC_OP_OR) ? or_c : and_c;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer_c) begin
      valid_d = 1'b1;
      tag_d   = sel_tag_c;
      data_d  = result_c;
      ptr_d   = (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + PTR_W'(1);
    end else if (cdb_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a per-cycle reference model.
module tb_logic_unit_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TW = 4;
  localparam int unsigned DW = 32;

  logic            clock = 1'b0;
  logic            reset, flush;
  logic [N-1:0]    req_valid, req_op, req_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*TW-1:0] req_tag;
  logic            cdb_valid, cdb_ready;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  // Reference state: what the result register and pointer must hold.
  logic          m_valid = 1'b0;
  logic [TW-1:0] m_tag   = '0;
  logic [DW-1:0] m_data  = '0;
  int            m_ptr   = 0;

  logic_unit_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_ready (cdb_ready),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Index of the requester that must win this cycle, or -1 for none.
  function automatic int exp_winner();
    if (reset || flush || (m_valid && !cdb_ready)) return -1;
    for (int k = 0; k < int'(N); k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    int w;
    g = '0;
    w = exp_winner();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  always @(posedge clock) begin
    int w;
    logic [DW-1:0] a, b;
    w = exp_winner();
    if (reset) begin
      m_valid <= 1'b0; m_tag <= '0; m_data <= '0; m_ptr <= 0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (w >= 0) begin
      a = req_a[w*DW +: DW];
      b = req_b[w*DW +: DW];
      m_valid <= 1'b1;
      m_tag   <= req_tag[w*TW +: TW];
      m_data  <= req_op[w] ? (a | b) : (a & b);
      m_ptr   <= (w + 1) % N;
    end else if (cdb_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("m_req_ready", 32'(req_ready), 32'(exp_grant()));
      chk("m_cdb_valid", 32'(cdb_valid), 32'(m_valid));
      chk("m_cdb_tag",   32'(cdb_tag),   32'(m_tag));
      chk("m_cdb_data",  cdb_data,       m_data);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [N-1:0] rr_seq [5];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1; flush = 1'b0; cdb_ready = 1'b0; req_valid = '0;
    req_op  = 4'b0101;
    req_a   = {32'hAAAA_AAAA, 32'h1234_0000, 32'hFFFF_00FF, 32'hF0F0_0000};
    req_b   = {32'hFFFF_0000, 32'h0000_5678, 32'h0F0F_0F0F, 32'h0000_0F0F};
    req_tag = {4'hC, 4'h9, 4'h5, 4'h3};

    @(posedge clock); #1;
    chk_on = 1'b1;
    req_valid = 4'b1111; cdb_ready = 1'b1;
    #1 chk("rst_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("rst_valid", 32'(cdb_valid), 32'h0);
    chk("rst_tag",   32'(cdb_tag),   32'h0);
    chk("rst_data",  cdb_data,       32'h0);

    // Single OR transfer with one-cycle latency
    reset = 1'b0; req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    #1;
    chk("t1_valid", 32'(cdb_valid), 32'h1);
    chk("t1_data",  cdb_data,       32'hF0F0_0F0F);
    chk("t1_tag",   32'(cdb_tag),   32'h3);

    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // Round-robin rotation with all requesters valid
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t2_rr", 32'(req_ready), 32'(rr_seq[k]));
      cyc();
    end

    // Backpressure holds the result and blocks grants
    cdb_ready = 1'b0; req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_ready", 32'(req_ready), 32'h0);
      chk("t3_valid", 32'(cdb_valid), 32'h1);
      chk("t3_data",  cdb_data,       32'hF0F0_0F0F);
      chk("t3_tag",   32'(cdb_tag),   32'h3);
      cyc();
    end
    cdb_ready = 1'b1;
    #1 chk("t3_refill", 32'(req_ready), 32'h2);
    cyc();
    #1;
    chk("t4_valid", 32'(cdb_valid), 32'h1);
    chk("t4_data",  cdb_data,       32'h0F0F_000F);
    chk("t4_tag",   32'(cdb_tag),   32'h5);

    // Flush drops the held result and leaves the pointer alone
    cdb_ready = 1'b0; req_valid = 4'b1000; flush = 1'b1;
    #1 chk("t5_ready", 32'(req_ready), 32'h0);
    cyc();
    flush = 1'b0;
    #1 chk("t5_valid", 32'(cdb_valid), 32'h0);
    req_valid = 4'b1111; cdb_ready = 1'b1;
    #1 chk("t5_ptr", 32'(req_ready), 32'h4);
    cyc();
    #1 chk("t5_data", cdb_data, 32'h1234_5678);

    // Reset during a live handshake
    reset = 1'b1;
    #1 chk("t6_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("t6_valid", 32'(cdb_valid), 32'h0);
    chk("t6_tag",   32'(cdb_tag),   32'h0);
    chk("t6_data",  cdb_data,       32'h0);
    reset = 1'b0;
    #1 chk("t6_first", 32'(req_ready), 32'h1);
    cyc();
    #1 chk("t6_tag2", 32'(cdb_tag), 32'h3);

    // Mixed traffic checked against the model only
    for (int k = 0; k < 60; k++) begin
      req_valid = N'($urandom);
      req_op    = N'($urandom);
      req_a     = {$urandom, $urandom, $urandom, $urandom};
      req_b     = {$urandom, $urandom, $urandom, $urandom};
      req_tag   = 16'($urandom);
      cdb_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      cyc();
    end
    flush = 1'b0; req_valid = '0; cdb_ready = 1'b1;
    cyc();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
